// File: rtl/mem_ctrl_if.sv
// Client/RAM-side signal bundle for mem_ctrl: fetch port, load/store port, byte RAM port.
// slave = the controller, master = the clients and RAM that face it.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_data;
    logic              if_done;
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic [31:0]       ls_rdata;
    logic              ls_done;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_full;

    modport slave (
        input  if_req, if_addr, if_flush, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din, io_full,
        output if_data, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr, if_flush, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din, io_full,
        input  if_data, if_done, ls_rdata, ls_done, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller: 32-bit little-endian fetch words and 1/2/4-byte LSB loads/stores, LSB priority.
// Optional MEMCTRL_IO_STALL_EN: I/O stores (ls_addr[17:16]==2'b11) wait in IDLE while io_full is high.
//
// state | meaning
// IDLE  | arbitrate; LSB request beats a pending/new fetch
// READ  | issue base+k, capture mem_din on the following edge
// WRITE | drive base+k / byte k with mem_wr
// DONE  | one-cycle done pulse, then back to IDLE
module mem_ctrl #(parameter int ADDR_W = 32) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic              owner_fetch;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend;
    logic [2:0]        cnt;
    logic [2:0]        last;
    logic [31:0]       wbuf;
    logic [31:0]       rbuf;

    logic [2:0]        nxt_idx;
    logic [2:0]        ls_last;
    logic [31:0]       rd_full;
    logic              io_block;
    logic              ls_win;
    logic              fetch_win;
    logic              fetch_busy;
    logic [ADDR_W-1:0] fetch_addr;

`ifdef MEMCTRL_IO_STALL_EN
    assign io_block = bus.ls_we && (bus.ls_addr[17:16] == 2'b11) && bus.io_full;
`else
    logic unused_io_full;
    assign unused_io_full = bus.io_full;
    assign io_block       = 1'b0;
`endif

    assign ls_win     = bus.ls_req && !io_block;
    // a same-cycle if_req is served directly so an idle fetch completes 5 cycles after its request
    assign fetch_win  = (pend || bus.if_req) && !bus.if_flush && !ls_win;
    assign fetch_addr = bus.if_req ? bus.if_addr : pend_addr;
    assign fetch_busy = (state != IDLE) && owner_fetch;
    assign nxt_idx    = cnt + 3'd1;
    assign ls_last    = (bus.ls_size == 2'd0) ? 3'd0 : (bus.ls_size == 2'd1) ? 3'd1 : 3'd3;

    always_comb begin
        rd_full = rbuf;
        rd_full[{cnt[1:0], 3'b000} +: 8] = bus.mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner_fetch  <= 1'b0;
            base         <= '0;
            pend_addr    <= '0;
            pend         <= 1'b0;
            cnt          <= 3'd0;
            last         <= 3'd0;
            wbuf         <= '0;
            rbuf         <= '0;
            bus.if_data  <= '0;
            bus.if_done  <= 1'b0;
            bus.ls_rdata <= '0;
            bus.ls_done  <= 1'b0;
            bus.mem_a    <= '0;
            bus.mem_dout <= '0;
            bus.mem_wr   <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.ls_done <= 1'b0;

            if (bus.if_flush) begin
                pend <= 1'b0;
            end else if (bus.if_req && !fetch_busy) begin
                pend      <= 1'b1;
                pend_addr <= bus.if_addr;
            end

            case (state)
                IDLE: begin
                    cnt  <= 3'd0;
                    rbuf <= '0;
                    if (ls_win) begin
                        owner_fetch <= 1'b0;
                        base        <= bus.ls_addr;
                        last        <= ls_last;
                        wbuf        <= bus.ls_wdata;
                        bus.mem_a   <= bus.ls_addr;
                        if (bus.ls_we) begin
                            state        <= WRITE;
                            bus.mem_wr   <= 1'b1;
                            bus.mem_dout <= bus.ls_wdata[7:0];
                        end else begin
                            state <= READ;
                        end
                    end else if (fetch_win) begin
                        owner_fetch <= 1'b1;
                        base        <= fetch_addr;
                        last        <= 3'd3;
                        bus.mem_a   <= fetch_addr;
                        pend        <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (owner_fetch && bus.if_flush) begin
                        state     <= IDLE;
                        bus.mem_a <= '0;
                    end else begin
                        rbuf <= rd_full;
                        if (cnt == last) begin
                            state     <= DONE;
                            bus.mem_a <= '0;
                            if (owner_fetch) begin
                                bus.if_data <= rd_full;
                                bus.if_done <= 1'b1;
                            end else begin
                                bus.ls_rdata <= rd_full;
                                bus.ls_done  <= 1'b1;
                            end
                        end else begin
                            cnt       <= nxt_idx;
                            bus.mem_a <= base + ADDR_W'(nxt_idx);
                        end
                    end
                end
                WRITE: begin
                    if (cnt == last) begin
                        state        <= DONE;
                        bus.mem_wr   <= 1'b0;
                        bus.mem_a    <= '0;
                        bus.mem_dout <= '0;
                        bus.ls_done  <= 1'b1;
                    end else begin
                        cnt          <= nxt_idx;
                        bus.mem_a    <= base + ADDR_W'(nxt_idx);
                        bus.mem_dout <= wbuf[{nxt_idx[1:0], 3'b000} +: 8];
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, done-event scoreboard and write-log scoreboard.
module tb_mem_ctrl;
    typedef struct packed {
        logic        is_fetch;
        logic        chk;
        logic [31:0] data;
        logic [31:0] cyc;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [31:0] cyc_n = 32'd0;
    int          vec   = 0;
    int          errs  = 0;

    logic [7:0]  ram [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_a  = 16'd0;
    logic [7:0]  pl_d  = 8'd0;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic [39:0] exp_wr_q[$];
    logic [39:0] wr_log[$];

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n <= cyc_n + 32'd1;

    assign bus.mem_din = ram[bus.mem_a[15:0]];

    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (bus.mem_wr === 1'b1) begin
            ram[bus.mem_a[15:0]] <= bus.mem_dout;
            wr_log.push_back({bus.mem_a, bus.mem_dout});
        end
    end

    always @(negedge clk) begin
        if (bus.if_done === 1'b1) obs_q.push_back('{1'b1, 1'b1, bus.if_data, cyc_n});
        if (bus.ls_done === 1'b1) obs_q.push_back('{1'b0, 1'b1, bus.ls_rdata, cyc_n});
    end

    // LSB client behaviour: ls_req is dropped in the ls_done cycle
    task automatic step();
        @(negedge clk);
        #1;
        if (bus.ls_done === 1'b1) bus.ls_req = 1'b0;
    endtask

    task automatic drive_idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_size  = 2'd0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        bus.io_full  = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            step();
            pl_we = 1'b1;
            pl_a  = a + 16'(k);
            pl_d  = w[8*k +: 8];
        end
        step();
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) step();
        vec += 7;
        if (bus.if_data  !== 32'h0) begin errs++; $display("FAIL reset_if_data got %h want 0", bus.if_data); end
        if (bus.if_done  !== 1'b0)  begin errs++; $display("FAIL reset_if_done got %b want 0", bus.if_done); end
        if (bus.ls_rdata !== 32'h0) begin errs++; $display("FAIL reset_ls_rdata got %h want 0", bus.ls_rdata); end
        if (bus.ls_done  !== 1'b0)  begin errs++; $display("FAIL reset_ls_done got %b want 0", bus.ls_done); end
        if (bus.mem_a    !== 32'h0) begin errs++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
        if (bus.mem_dout !== 8'h0)  begin errs++; $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); end
        if (bus.mem_wr   !== 1'b0)  begin errs++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        logic [31:0] t0;
        ev_t ev, ob;
        step();
        t0 = cyc_n;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        exp_q.push_back('{1'b1, 1'b1, 32'h44332211, t0 + 32'd5});
        for (int k = 0; k < 4; k++) begin
            step();
            bus.if_req = 1'b0;
            vec++;
            if (bus.mem_a !== 32'(32'h100 + k)) begin
                errs++; $display("FAIL fetch_mem_a[%0d] got %h want %h", k, bus.mem_a, 32'(32'h100 + k));
            end
        end
        for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) step();
        step();
        vec += 2;
        if (bus.if_done !== 1'b0) begin errs++; $display("FAIL fetch_done_width got %b want 0", bus.if_done); end
        if (bus.mem_a !== 32'h0) begin errs++; $display("FAIL fetch_mem_a_idle got %h want 0", bus.mem_a); end
        vec++;
        if (obs_q.size() != exp_q.size()) begin
            errs++; $display("FAIL fetch_done_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            ev = exp_q.pop_front(); ob = obs_q.pop_front(); vec++;
            if (ob.is_fetch !== ev.is_fetch || ob.cyc !== ev.cyc || (ev.chk && ob.data !== ev.data)) begin
                errs++; $display("FAIL fetch_done got f%0d %h @%0d want f%0d %h @%0d", ob.is_fetch, ob.data, ob.cyc, ev.is_fetch, ev.data, ev.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_arbitration();
        logic [31:0] t0;
        ev_t ev, ob;
        step();
        t0 = cyc_n;
        bus.if_req  = 1'b1; bus.if_addr = 32'h200;
        bus.ls_req  = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h300;
        exp_q.push_back('{1'b0, 1'b1, 32'h87654321, t0 + 32'd5});
        exp_q.push_back('{1'b1, 1'b1, 32'h0D0C0B0A, t0 + 32'd11});
        step();
        bus.if_req = 1'b0;
        for (int i = 0; i < 30 && obs_q.size() < exp_q.size(); i++) step();
        repeat (4) step();
        vec++;
        if (obs_q.size() != exp_q.size()) begin
            errs++; $display("FAIL arb_done_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            ev = exp_q.pop_front(); ob = obs_q.pop_front(); vec++;
            if (ob.is_fetch !== ev.is_fetch || ob.cyc !== ev.cyc || (ev.chk && ob.data !== ev.data)) begin
                errs++; $display("FAIL arb_done got f%0d %h @%0d want f%0d %h @%0d", ob.is_fetch, ob.data, ob.cyc, ev.is_fetch, ev.data, ev.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_pend_overwrite();
        logic [31:0] t0;
        ev_t ev, ob;
        step();
        t0 = cyc_n;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'h300;
        exp_q.push_back('{1'b0, 1'b1, 32'h00000021, t0 + 32'd2});
        exp_q.push_back('{1'b1, 1'b1, 32'hCAFEF00D, t0 + 32'd8});
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        step();
        bus.if_addr = 32'h600;
        step();
        bus.if_req = 1'b0;
        for (int i = 0; i < 30 && obs_q.size() < exp_q.size(); i++) step();
        repeat (3) step();
        vec++;
        if (obs_q.size() != exp_q.size()) begin
            errs++; $display("FAIL pend_done_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            ev = exp_q.pop_front(); ob = obs_q.pop_front(); vec++;
            if (ob.is_fetch !== ev.is_fetch || ob.cyc !== ev.cyc || (ev.chk && ob.data !== ev.data)) begin
                errs++; $display("FAIL pend_done got f%0d %h @%0d want f%0d %h @%0d", ob.is_fetch, ob.data, ob.cyc, ev.is_fetch, ev.data, ev.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_store_load();
        logic [31:0] t0;
        int ws;
        ev_t ev, ob;
        step();
        ws = wr_log.size();
        t0 = cyc_n;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd1; bus.ls_addr = 32'h401; bus.ls_wdata = 32'h1234BEEF;
        exp_q.push_back('{1'b0, 1'b0, 32'h0, t0 + 32'd3});
        exp_wr_q.push_back({32'h401, 8'hEF});
        exp_wr_q.push_back({32'h402, 8'hBE});
        step();
        vec += 3;
        if (bus.mem_wr !== 1'b1) begin errs++; $display("FAIL st_wr0 got %b want 1", bus.mem_wr); end
        if (bus.mem_a !== 32'h401) begin errs++; $display("FAIL st_a0 got %h want 401", bus.mem_a); end
        if (bus.mem_dout !== 8'hEF) begin errs++; $display("FAIL st_d0 got %h want ef", bus.mem_dout); end
        step();
        vec += 2;
        if (bus.mem_a !== 32'h402) begin errs++; $display("FAIL st_a1 got %h want 402", bus.mem_a); end
        if (bus.mem_dout !== 8'hBE) begin errs++; $display("FAIL st_d1 got %h want be", bus.mem_dout); end
        step();
        vec++;
        if (bus.mem_wr !== 1'b0) begin errs++; $display("FAIL st_wr_done got %b want 0", bus.mem_wr); end
        // new request raised in the done cycle is only accepted from IDLE, one cycle later
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'h402;
        exp_q.push_back('{1'b0, 1'b1, 32'h000000BE, t0 + 32'd6});
        for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) step();
        repeat (3) step();
        vec++;
        if (obs_q.size() != exp_q.size()) begin
            errs++; $display("FAIL stld_done_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            ev = exp_q.pop_front(); ob = obs_q.pop_front(); vec++;
            if (ob.is_fetch !== ev.is_fetch || ob.cyc !== ev.cyc || (ev.chk && ob.data !== ev.data)) begin
                errs++; $display("FAIL stld_done got f%0d %h @%0d want f%0d %h @%0d", ob.is_fetch, ob.data, ob.cyc, ev.is_fetch, ev.data, ev.cyc);
            end
        end
        vec++;
        if (wr_log.size() - ws != exp_wr_q.size()) begin
            errs++; $display("FAIL st_write_count got %0d want %0d", wr_log.size() - ws, exp_wr_q.size());
        end
        for (int i = 0; i < exp_wr_q.size() && ws + i < wr_log.size(); i++) begin
            vec++;
            if (wr_log[ws + i] !== exp_wr_q[i]) begin
                errs++; $display("FAIL st_write[%0d] got %h want %h", i, wr_log[ws + i], exp_wr_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete(); exp_wr_q.delete();
    endtask

    task automatic test_flush();
        logic [31:0] t0;
        ev_t ev, ob;
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        step();
        bus.if_req = 1'b0;
        step();
        vec++;
        if (bus.mem_a !== 32'h501) begin errs++; $display("FAIL flush_pre_a got %h want 501", bus.mem_a); end
        bus.if_flush = 1'b1;
        step();
        bus.if_flush = 1'b0;
        vec += 2;
        if (bus.mem_a !== 32'h0) begin errs++; $display("FAIL flush_mem_a got %h want 0", bus.mem_a); end
        if (bus.if_done !== 1'b0) begin errs++; $display("FAIL flush_if_done got %b want 0", bus.if_done); end
        t0 = cyc_n;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        exp_q.push_back('{1'b1, 1'b1, 32'h04030201, t0 + 32'd5});
        step();
        bus.if_req = 1'b0;
        for (int i = 0; i < 20 && obs_q.size() < exp_q.size(); i++) step();
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h500; bus.if_flush = 1'b1;
        step();
        bus.if_req = 1'b0; bus.if_flush = 1'b0;
        repeat (10) step();
        vec++;
        if (obs_q.size() != exp_q.size()) begin
            errs++; $display("FAIL flush_done_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            ev = exp_q.pop_front(); ob = obs_q.pop_front(); vec++;
            if (ob.is_fetch !== ev.is_fetch || ob.cyc !== ev.cyc || (ev.chk && ob.data !== ev.data)) begin
                errs++; $display("FAIL flush_done got f%0d %h @%0d want f%0d %h @%0d", ob.is_fetch, ob.data, ob.cyc, ev.is_fetch, ev.data, ev.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_rst_mid_store();
        int ws;
        step();
        ws = wr_log.size();
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd2; bus.ls_addr = 32'h700; bus.ls_wdata = 32'hA1B2C3D4;
        exp_wr_q.push_back({32'h700, 8'hD4});
        exp_wr_q.push_back({32'h701, 8'hC3});
        step();
        step();
        rst = 1'b1;
        step();
        vec += 7;
        if (bus.if_data  !== 32'h0) begin errs++; $display("FAIL rst_if_data got %h want 0", bus.if_data); end
        if (bus.if_done  !== 1'b0)  begin errs++; $display("FAIL rst_if_done got %b want 0", bus.if_done); end
        if (bus.ls_rdata !== 32'h0) begin errs++; $display("FAIL rst_ls_rdata got %h want 0", bus.ls_rdata); end
        if (bus.ls_done  !== 1'b0)  begin errs++; $display("FAIL rst_ls_done got %b want 0", bus.ls_done); end
        if (bus.mem_a    !== 32'h0) begin errs++; $display("FAIL rst_mem_a got %h want 0", bus.mem_a); end
        if (bus.mem_dout !== 8'h0)  begin errs++; $display("FAIL rst_mem_dout got %h want 0", bus.mem_dout); end
        if (bus.mem_wr   !== 1'b0)  begin errs++; $display("FAIL rst_mem_wr got %b want 0", bus.mem_wr); end
        rst = 1'b0;
        bus.ls_req = 1'b0;
        repeat (6) step();
        vec += 2;
        if (obs_q.size() != 0) begin errs++; $display("FAIL rst_done_count got %0d want 0", obs_q.size()); end
        if (ram[16'h0702] !== 8'h00) begin errs++; $display("FAIL rst_byte2 got %h want 00", ram[16'h0702]); end
        vec++;
        if (wr_log.size() - ws != exp_wr_q.size()) begin
            errs++; $display("FAIL rst_write_count got %0d want %0d", wr_log.size() - ws, exp_wr_q.size());
        end
        for (int i = 0; i < exp_wr_q.size() && ws + i < wr_log.size(); i++) begin
            vec++;
            if (wr_log[ws + i] !== exp_wr_q[i]) begin
                errs++; $display("FAIL rst_write[%0d] got %h want %h", i, wr_log[ws + i], exp_wr_q[i]);
            end
        end
        obs_q.delete(); exp_wr_q.delete();
    endtask

    task automatic test_io_store();
        logic [31:0] t0;
        int ws;
        ev_t ev, ob;
        step();
        ws = wr_log.size();
        t0 = cyc_n;
        bus.io_full = 1'b1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd0; bus.ls_addr = 32'h30000; bus.ls_wdata = 32'h000000AB;
        exp_wr_q.push_back({32'h30000, 8'hAB});
`ifdef MEMCTRL_IO_STALL_EN
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        exp_q.push_back('{1'b1, 1'b1, 32'h44332211, t0 + 32'd5});
        exp_q.push_back('{1'b0, 1'b0, 32'h0, t0 + 32'd12});
        step();
        bus.if_req = 1'b0;
        repeat (9) step();
        vec++;
        if (wr_log.size() != ws) begin errs++; $display("FAIL io_held_writes got %0d want 0", wr_log.size() - ws); end
        bus.io_full = 1'b0;
`else
        exp_q.push_back('{1'b0, 1'b0, 32'h0, t0 + 32'd2});
`endif
        for (int i = 0; i < 30 && obs_q.size() < exp_q.size(); i++) step();
        repeat (3) step();
        bus.io_full = 1'b0;
        vec++;
        if (obs_q.size() != exp_q.size()) begin
            errs++; $display("FAIL io_done_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            ev = exp_q.pop_front(); ob = obs_q.pop_front(); vec++;
            if (ob.is_fetch !== ev.is_fetch || ob.cyc !== ev.cyc || (ev.chk && ob.data !== ev.data)) begin
                errs++; $display("FAIL io_done got f%0d %h @%0d want f%0d %h @%0d", ob.is_fetch, ob.data, ob.cyc, ev.is_fetch, ev.data, ev.cyc);
            end
        end
        vec++;
        if (wr_log.size() - ws != exp_wr_q.size()) begin
            errs++; $display("FAIL io_write_count got %0d want %0d", wr_log.size() - ws, exp_wr_q.size());
        end
        for (int i = 0; i < exp_wr_q.size() && ws + i < wr_log.size(); i++) begin
            vec++;
            if (wr_log[ws + i] !== exp_wr_q[i]) begin
                errs++; $display("FAIL io_write[%0d] got %h want %h", i, wr_log[ws + i], exp_wr_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete(); exp_wr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        preload(16'h0100, 32'h44332211);
        preload(16'h0200, 32'h0D0C0B0A);
        preload(16'h0300, 32'h87654321);
        preload(16'h0600, 32'hCAFEF00D);
        preload(16'h0500, 32'h55667788);
        preload(16'h0010, 32'h04030201);
        preload(16'h0700, 32'h00000000);
        test_reset();
        test_fetch();
        test_arbitration();
        test_pend_overwrite();
        test_store_load();
        test_flush();
        test_rst_mid_store();
        test_io_store();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
